// File: rtl/counter_modn_pkg.sv
// Shared constants and parameter checks for the clock datapath counters.
package counter_modn_pkg;

  localparam int SEC_MOD     = 60;
  localparam int MIN_MOD     = 60;
  localparam int HR24_MOD    = 24;
  localparam int HR12_MOD    = 12;
  localparam int BCD_W       = 4;
  localparam int MAX_MODULUS = 100;

  // Legal when the modulus fits the two-digit display and the counter width.
  // The reset value must also lie inside the count range.
  function automatic bit params_ok(input int modulus, input int width, input int reset_val);
    return (modulus >= 2) && (modulus <= MAX_MODULUS) &&
           (width >= 1) && (width <= 32) &&
           ((longint'(1) << width) >= longint'(modulus)) &&
           (reset_val >= 0) && (reset_val < modulus);
  endfunction

endpackage

// File: rtl/counter_bcd_split.sv
// Combinational binary (0..99) to two BCD digits.
module counter_bcd_split
  import counter_modn_pkg::*;
(
  input  logic [6:0]       bin_in,
  output logic [BCD_W-1:0] tens_out,
  output logic [BCD_W-1:0] ones_out
);

  always_comb begin
    tens_out = BCD_W'(bin_in / 7'd10);
    ones_out = BCD_W'(bin_in % 7'd10);
  end

endmodule

// File: rtl/counter_modn.sv
// Modulo-N up/down counter with preset load, cascade terminal count and
// registered BCD digits for the display path.
module counter_modn
  import counter_modn_pkg::*;
#(
  parameter int MODULUS   = 60,
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             en_in,
  input  logic             up_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  output logic [WIDTH-1:0] count_out,
  output logic [3:0]       bcd_tens_out,
  output logic [3:0]       bcd_ones_out,
  output logic             tc_out,
  output logic             load_err_out
);

  if (!params_ok(MODULUS, WIDTH, RESET_VAL)) begin : g_param_check
    $error("counter_modn: illegal MODULUS/WIDTH/RESET_VAL combination");
  end

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [3:0]       RST_TENS = 4'(RESET_VAL / 10);
  localparam logic [3:0]       RST_ONES = 4'(RESET_VAL % 10);

  logic [WIDTH-1:0] count_q, count_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             err_q, err_d;

  // Out-of-range loads saturate to the top of the range instead of wrapping.
  always_comb begin
    count_d = count_q;
    err_d   = 1'b0;
    if (load_in) begin
      if (load_val_in <= MAX_VAL) begin
        count_d = load_val_in;
      end else begin
        count_d = MAX_VAL;
        err_d   = 1'b1;
      end
    end else if (en_in) begin
      if (up_in) begin
        count_d = (count_q == MAX_VAL) ? '0 : count_q + ONE;
      end else begin
        count_d = (count_q == '0) ? MAX_VAL : count_q - ONE;
      end
    end
  end

  counter_bcd_split u_bcd_split (
    .bin_in   (7'(count_d)),
    .tens_out (tens_d),
    .ones_out (ones_d)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      count_q <= RST_VAL;
      tens_q  <= RST_TENS;
      ones_q  <= RST_ONES;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      err_q   <= err_d;
    end
  end

  // Combinational so the next stage steps on the same edge as this one wraps.
  assign tc_out = en_in & ~load_in & reset_in &
                  (up_in ? (count_q == MAX_VAL) : (count_q == '0));

  assign count_out    = count_q;
  assign bcd_tens_out = tens_q;
  assign bcd_ones_out = ones_q;
  assign load_err_out = err_q;

endmodule

// File: doc/counter_modn.md
# counter_modn

Parametrised modulo-N counter: the general successor to the fixed 0–59 minute counter for the clock datapath. It adds enable, up/down counting, synchronous preset load (time-set), a terminal-count output for same-cycle cascading, and registered two-digit BCD outputs for the display path. Seconds, minutes and hours stages are all instances of this block chained through `tc_out`.

## Interface
Parameters:
- `MODULUS`, 60: count range 0..MODULUS-1; legal 2..100.
- `WIDTH`, 8: counter width; must satisfy 2^WIDTH >= MODULUS.
- `RESET_VAL`, 0: value loaded on reset; must be < MODULUS.

Ports:
- `clk_in`  in  1  single clock; all state changes on the rising edge.
- `reset_in`  in  1  synchronous, active-low reset.
- `en_in`  in  1  count enable; one step per cycle while high.
- `up_in`  in  1  direction: 1 = increment, 0 = decrement.
- `load_in`  in  1  synchronous preset strobe.
- `load_val_in`  in  WIDTH  preset value.
- `count_out`  out  WIDTH  registered count.
- `bcd_tens_out`  out  4  registered tens digit of `count_out`.
- `bcd_ones_out`  out  4  registered ones digit of `count_out`.
- `tc_out`  out  1  combinational terminal count for cascading.
- `load_err_out`  out  1  registered one-cycle pulse on an out-of-range load.

## Operation
- Priority per edge: reset > load > enable > hold.
- Reset (`reset_in`=0 at an edge): `count_out`=RESET_VAL, BCD outputs = digits of RESET_VAL, `load_err_out`=0. Reset mid-count or mid-load discards the step or load.
- Load (`load_in`=1): if `load_val_in` < MODULUS, count takes `load_val_in`. Otherwise count takes MODULUS-1 and `load_err_out` pulses for one cycle. `en_in` is ignored in a load cycle.
- Count (`en_in`=1, no load):
  - up: MODULUS-1 -> 0, else +1.
  - down: 0 -> MODULUS-1, else -1.
- Hold: `en_in`=0 and no load keeps all registers unchanged. `load_err_out` returns to 0.
- `tc_out` = `en_in` & ~`load_in` & reset_in & (up ? count==MODULUS-1 : count==0). The next stage's `en_in` is driven from `tc_out`, so a cascade rolls over on the same edge.
- Width rule: compare and wrap in WIDTH bits. No intermediate value ever exceeds MODULUS-1. Count never leaves 0..MODULUS-1.
- BCD: tens = value/10, ones = value%10. Both are computed from the next-state value and registered on the same edge as the count, so all three outputs are always coherent.

## Timing
- Count, BCD and `load_err_out` have 1-cycle latency from the qualifying edge. There are no extra pipeline stages.
- `tc_out` is combinational from the current count and inputs, with zero latency. It is valid in the cycle before the wrap edge.
- Direction change takes effect on the next enabled edge. No idle cycle is required.
- Simultaneous `load_in` and `en_in`: load wins, no step, `tc_out`=0.
- Load of exactly MODULUS-1 is legal, with no error pulse.
- Back-to-back bad loads: `load_err_out` stays high for each such cycle.

## Structure
- Shared clock package holds:
  - the modulus constants: SEC_MOD=60, MIN_MOD=60, HR24_MOD=24, HR12_MOD=12;
  - the BCD digit width of 4;
  - the checks that elaboration fails if MODULUS > 100, 2^WIDTH < MODULUS, or RESET_VAL ≥ MODULUS.
- One sub-module, `counter_bcd_split`: combinational binary (0..99) to tens/ones. It is instantiated on the next-state value ahead of the output registers.

## Test plan
- Reset then up-count: reset_in=0 for 2 cycles, then en_in=1, up_in=1 for 61 cycles -> count 0,1..59,0,1. `tc_out`=1 only while count=59. At count=59 the BCD outputs read 5/9.
- Down wrap: load 0, then en_in=1, up_in=0 -> next count 59, BCD 5/9. `tc_out` is high in the cycle count=0.
- Load precedence and error: load_in=1, en_in=1, load_val_in=75, MODULUS=60 -> count 59, `load_err_out`=1 for one cycle, no step. Then load 23 -> count 23, no error.
- Cascade: seconds stage feeds the `en_in` of a minutes stage through `tc_out`. Load seconds=59, minutes=59, then one enabled up-edge -> both read 0 on the same edge.
- Mid-operation reset: with RESET_VAL=12 and MODULUS=24, count to 17, then drop reset_in together with en_in=1 and load_in=1 -> count 12, BCD 1/2, `load_err_out`=0. `tc_out`=0 while reset is low.
- Hold: en_in=0 for 10 cycles at count 42 -> count, BCD 4/2 and `tc_out`=0 all stay stable.
